// File: rtl/hex_disp_pkg.sv
// ---------------------------------------------------------------------------
// hex_disp_pkg
//   Shared constants and helpers for the multiplexed 7-segment display driver.
//   - SEG_BLANK : all segments off (active-low gfedcba)
//   - SEG_LUT   : hex digit 0..F to active-low gfedcba segment pattern
//   - blinkState_t : phase of the per-digit blink generator
//   - cntWidth  : counter width for a modulus, never narrower than one bit
// ---------------------------------------------------------------------------
package hex_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Bit 6 = g ... bit 0 = a, a zero bit lights the segment.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blinkState_t;

  // Width needed to count 0..n-1; a modulus of 1 still gets a 1-bit counter
  // so that the register declarations stay legal.
  function automatic int cntWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_seg_lut.sv
// ---------------------------------------------------------------------------
// hex_seg_lut
//   Combinational hex nibble to 7-segment decoder (active-low gfedcba).
//   Any nibble that does not match a defined code (X/Z in simulation)
//   decodes to all segments dark.
// Ports
//   nibble_i  in  4  hex value to display
//   seg_o     out 7  segment pattern, active-low, bit 6 = g, bit 0 = a
// ---------------------------------------------------------------------------
module hex_seg_lut
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Table lookup by explicit comparison, so an unknown nibble matches no
  // entry and falls through to the blank pattern.
  always_comb begin
    seg_o = SEG_BLANK;
    for (int v = 0; v < 16; v++) begin
      if (nibble_i == 4'(v)) begin
        seg_o = SEG_LUT[v];
      end
    end
  end

endmodule

// File: rtl/hex_display_scan.sv
// ---------------------------------------------------------------------------
// hex_display_scan
//   Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.
//   A packed hex word and per-digit decimal points are captured into pending
//   registers and copied to the displayed registers only at the end of a full
//   scan frame, so a digit never shows a mix of old and new data. One digit is
//   driven per slot of SCAN_DIV clocks. Leading zeros can be blanked and any
//   digit can blink with a half-period of BLINK_FRAMES frames.
// Parameters
//   DIGITS        digits scanned (1..16)
//   SCAN_DIV      clk_i cycles per digit slot (>= 2)
//   BLINK_FRAMES  full frames per blink half-period (>= 1)
// Ports
//   clk_i         in   1         system clock
//   rst_i         in   1         asynchronous reset, active-high
//   en_i          in   1         display enable; 0 = dark and counters frozen
//   load_i        in   1         capture strobe for data_i / dp_i
//   data_i        in   4*DIGITS  nibble k drives digit k (digit 0 rightmost)
//   dp_i          in   DIGITS    decimal point per digit, 1 = lit
//   blink_mask_i  in   DIGITS    1 = digit blinks
//   blank_lz_i    in   1         1 = suppress leading zeros
//   hex_o         out  7         segments gfedcba, active-low
//   dp_o          out  1         decimal point, active-low
//   an_o          out  DIGITS    anode select, active-low, one-hot-cold
//   frame_o       out  1         high on the last cycle of every scan frame
// ---------------------------------------------------------------------------
module hex_display_scan
  import hex_disp_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] data_i,
  input  logic [DIGITS-1:0]   dp_i,
  input  logic [DIGITS-1:0]   blink_mask_i,
  input  logic                blank_lz_i,
  output logic [6:0]          hex_o,
  output logic                dp_o,
  output logic [DIGITS-1:0]   an_o,
  output logic                frame_o
);

  localparam int PRE_W = cntWidth(SCAN_DIV);
  localparam int IDX_W = cntWidth(DIGITS);
  localparam int BLK_W = cntWidth(BLINK_FRAMES);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  logic [PRE_W-1:0]    prescaler_q, prescaler_d;
  logic [IDX_W-1:0]    digitIdx_q, digitIdx_d;
  logic [BLK_W-1:0]    blinkCnt_q, blinkCnt_d;
  blinkState_t         blinkState_q, blinkState_d;

  logic [4*DIGITS-1:0] pendData_q, pendData_d;
  logic [DIGITS-1:0]   pendDp_q, pendDp_d;
  logic [4*DIGITS-1:0] shownData_q, shownData_d;
  logic [DIGITS-1:0]   shownDp_q, shownDp_d;

  logic [6:0]          hex_q, hex_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                slotEnd;
  logic                frameEnd;
  logic [DIGITS-1:0]   lzBlank;
  logic [3:0]          selNibble;
  logic                selDp;
  logic                selBlinkOff;
  logic                selLz;
  logic [DIGITS-1:0]   selAn;
  logic [6:0]          lutSeg;

  // Scan timing. The prescaler and digit index only move while enabled, so
  // disabling the display simply stretches the current slot. A frame ends on
  // the prescaler wrap of the last digit; that same cycle is reported on
  // frame_o and is the only cycle on which the shown registers change.
  always_comb begin
    slotEnd     = en_i && (prescaler_q == PRE_LAST);
    frameEnd    = slotEnd && (digitIdx_q == IDX_LAST);
    prescaler_d = prescaler_q;
    digitIdx_d  = digitIdx_q;
    if (en_i) begin
      prescaler_d = (prescaler_q == PRE_LAST) ? '0 : prescaler_q + 1'b1;
    end
    if (slotEnd) begin
      digitIdx_d = (digitIdx_q == IDX_LAST) ? '0 : digitIdx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prescaler_q <= '0;
      digitIdx_q  <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      digitIdx_q  <= digitIdx_d;
    end
  end

  // Blink generator: counts completed frames and flips between the ON and
  // OFF phases every BLINK_FRAMES frames. Because it only advances on frame
  // ends, a blinking digit is dark for whole frames, never part of one.
  always_comb begin
    blinkState_d = blinkState_q;
    blinkCnt_d   = blinkCnt_q;
    if (frameEnd) begin
      if (blinkCnt_q == BLK_LAST) begin
        blinkCnt_d = '0;
        unique case (blinkState_q)
          BLINK_ON:  blinkState_d = BLINK_OFF;
          BLINK_OFF: blinkState_d = BLINK_ON;
          default:   blinkState_d = BLINK_ON;
        endcase
      end else begin
        blinkCnt_d = blinkCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blinkState_q <= BLINK_ON;
      blinkCnt_q   <= '0;
    end else begin
      blinkState_q <= blinkState_d;
      blinkCnt_q   <= blinkCnt_d;
    end
  end

  // Double buffer. Loads always land in the pending registers (even while
  // the display is disabled). At a frame end the shown registers take the
  // pending copy, except when a load arrives on that very cycle: then the
  // fresh input is forwarded so it is not delayed by a whole extra frame.
  always_comb begin
    pendData_d  = pendData_q;
    pendDp_d    = pendDp_q;
    shownData_d = shownData_q;
    shownDp_d   = shownDp_q;
    if (load_i) begin
      pendData_d = data_i;
      pendDp_d   = dp_i;
    end
    if (frameEnd) begin
      shownData_d = load_i ? data_i : pendData_q;
      shownDp_d   = load_i ? dp_i   : pendDp_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pendData_q  <= '0;
      pendDp_q    <= '0;
      shownData_q <= '0;
      shownDp_q   <= '0;
    end else begin
      pendData_q  <= pendData_d;
      pendDp_q    <= pendDp_d;
      shownData_q <= shownData_d;
      shownDp_q   <= shownDp_d;
    end
  end

  // Leading-zero mask, walked from the most significant digit down: a digit
  // is a leading zero while every nibble from it upwards is zero. Digit 0 is
  // excluded so a displayed value of zero still reads "0".
  always_comb begin : lzScan
    logic zeroAbove;
    lzBlank   = '0;
    zeroAbove = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zeroAbove  = zeroAbove && (shownData_q[4*k +: 4] == 4'h0);
      lzBlank[k] = blank_lz_i && (k != 0) && zeroAbove;
    end
  end

  // Pick everything belonging to the digit currently being scanned.
  always_comb begin
    selNibble   = 4'h0;
    selDp       = 1'b0;
    selBlinkOff = 1'b0;
    selLz       = 1'b0;
    selAn       = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (digitIdx_q == IDX_W'(k)) begin
        selNibble   = shownData_q[4*k +: 4];
        selDp       = shownDp_q[k];
        selBlinkOff = blink_mask_i[k] && (blinkState_q == BLINK_OFF);
        selLz       = lzBlank[k];
        selAn[k]    = 1'b0;
      end
    end
  end

  hex_seg_lut u_seg_lut (
    .nibble_i (selNibble),
    .seg_o    (lutSeg)
  );

  // Output stage. Leading-zero blanking only darkens the segments; the
  // decimal point of such a digit stays visible, whereas the blink OFF phase
  // darkens the whole digit including its decimal point.
  always_comb begin
    hex_d = SEG_BLANK;
    dp_d  = 1'b1;
    an_d  = '1;
    if (en_i) begin
      an_d  = selAn;
      hex_d = (selBlinkOff || selLz) ? SEG_BLANK : lutSeg;
      dp_d  = ~(selDp && !selBlinkOff);
    end
  end

  // Registering the pins keeps anode switching glitch-free; the slot for
  // digit k therefore appears one cycle after the index reaches k.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hex_q <= SEG_BLANK;
      dp_q  <= 1'b1;
      an_q  <= '1;
    end else begin
      hex_q <= hex_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign hex_o   = hex_q;
  assign dp_o    = dp_q;
  assign an_o    = an_q;
  assign frame_o = frameEnd;

endmodule

// File: tb/tb_hex_display_scan.sv
// ---------------------------------------------------------------------------
// tb_hex_display_scan
//   Self-checking bench for hex_display_scan with DIGITS=4, SCAN_DIV=4,
//   BLINK_FRAMES=2. A behavioural model derives the scan position and blink
//   phase from the number of enabled cycles since reset and is compared with
//   the DUT on every falling edge; directed scenarios pin literal values.
// ---------------------------------------------------------------------------
module tb_hex_display_scan;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int PERIOD       = DIGITS * SCAN_DIV;

  localparam logic [6:0] SEG_REF [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [3:0] AN_REF [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        en        = 1'b1;
  logic        load      = 1'b0;
  logic [15:0] data      = 16'h0000;
  logic [3:0]  dp        = 4'h0;
  logic [3:0]  blinkMask = 4'h0;
  logic        blankLz   = 1'b0;
  logic [6:0]  hex;
  logic        dpOut;
  logic [3:0]  an;
  logic        frame;

  int          errors   = 0;
  int          checks   = 0;
  logic        checking = 1'b0;
  int unsigned cycCount = 0;

  logic [6:0]  capHex [4];
  logic        capDp  [4];
  logic [3:0]  capAn  [4];

  hex_display_scan #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .load_i       (load),
    .data_i       (data),
    .dp_i         (dp),
    .blink_mask_i (blinkMask),
    .blank_lz_i   (blankLz),
    .hex_o        (hex),
    .dp_o         (dpOut),
    .an_o         (an),
    .frame_o      (frame)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycCount <= cycCount + 1;

  // Reference model state: enabled cycles since reset, plus both data copies.
  int unsigned mActive  = 0;
  logic [15:0] mPend    = '0;
  logic [15:0] mShown   = '0;
  logic [3:0]  mPendDp  = '0;
  logic [3:0]  mShownDp = '0;
  logic [6:0]  mHex     = 7'h7F;
  logic        mDp      = 1'b1;
  logic [3:0]  mAn      = 4'hF;

  function automatic int refDigit();
    return int'((mActive / SCAN_DIV) % DIGITS);
  endfunction

  function automatic logic refBlinkOff();
    return (((mActive / PERIOD) / BLINK_FRAMES) % 2) == 1;
  endfunction

  function automatic logic refFrameEnd();
    return ((mActive + 1) % PERIOD) == 0;
  endfunction

  function automatic logic [6:0] refHex();
    int         k;
    logic [3:0] nib;
    logic       lz;
    logic       off;
    k   = refDigit();
    nib = 4'((mShown >> (4 * k)) & 16'hF);
    lz  = blankLz && (k != 0) && ((mShown >> (4 * k)) == 16'h0);
    off = blinkMask[k] && refBlinkOff();
    return (lz || off) ? 7'h7F : SEG_REF[nib];
  endfunction

  function automatic logic refDp();
    int k;
    k = refDigit();
    return !(mShownDp[k] && !(blinkMask[k] && refBlinkOff()));
  endfunction

  // Model advance: outputs reflect the slot before this edge; frame ends
  // swap in the pending copy (or a same-cycle load).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mActive  <= 0;
      mPend    <= '0;
      mShown   <= '0;
      mPendDp  <= '0;
      mShownDp <= '0;
      mHex     <= 7'h7F;
      mDp      <= 1'b1;
      mAn      <= 4'hF;
    end else begin
      if (en) begin
        mHex <= refHex();
        mDp  <= refDp();
        mAn  <= ~(4'b0001 << refDigit());
      end else begin
        mHex <= 7'h7F;
        mDp  <= 1'b1;
        mAn  <= 4'hF;
      end
      if (en && refFrameEnd()) begin
        mShown   <= load ? data : mPend;
        mShownDp <= load ? dp : mPendDp;
      end
      if (load) begin
        mPend   <= data;
        mPendDp <= dp;
      end
      if (en) mActive <= mActive + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst && checking) begin
      checkOutput("model_hex", hex, mHex);
      checkOutput("model_dp", dpOut, mDp);
      checkOutput("model_an", an, mAn);
      checkOutput("model_frame", frame, en && refFrameEnd());
    end
  end

  // Stops on the falling edge of a frame-end cycle, or gives up.
  task automatic waitFrame();
    int n;
    n = 0;
    @(negedge clk);
    while (!frame && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frame_seen", frame, 1'b1);
  endtask

  task automatic applyLoad(input logic [15:0] word, input logic [3:0] dots);
    @(posedge clk); #1;
    load = 1'b1;
    data = word;
    dp   = dots;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Records the outputs of every slot of the frame that follows the next
  // frame end.
  task automatic captureFrame();
    waitFrame();
    for (int k = 0; k < DIGITS; k++) begin
      repeat ((k == 0) ? 2 : SCAN_DIV) @(posedge clk);
      #1;
      capHex[k] = hex;
      capDp[k]  = dpOut;
      capAn[k]  = an;
    end
  endtask

  task automatic checkCapture(input string tag, input logic [27:0] expHex,
                              input logic [3:0] expDp);
    for (int k = 0; k < DIGITS; k++) begin
      checkOutput($sformatf("%s_hex%0d", tag, k), capHex[k], expHex[7*k +: 7]);
      checkOutput($sformatf("%s_dp%0d", tag, k), capDp[k], expDp[k]);
      checkOutput($sformatf("%s_an%0d", tag, k), capAn[k], AN_REF[k]);
    end
  endtask

  function automatic logic [15:0] randWord();
    logic [15:0] w;
    for (int k = 0; k < 4; k++) begin
      w[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
    end
    return w;
  endfunction

  task automatic applyStimulus();
    @(posedge clk); #1;
    en   = ($urandom_range(0, 9) != 0);
    load = ($urandom_range(0, 5) == 0);
    if (load) begin
      data = randWord();
      dp   = 4'($urandom_range(0, 15));
    end
    if ($urandom_range(0, 49) == 0) blinkMask = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 49) == 0) blankLz = ~blankLz;
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    int unsigned t0;
    int unsigned t1;
    int unsigned t2;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    checking = 1'b1;

    applyLoad(16'h12AF, 4'b0010);
    captureFrame();
    checkCapture("word12AF", {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1101);

    blankLz = 1'b1;
    applyLoad(16'h0050, 4'b0000);
    captureFrame();
    checkCapture("lz0050", {7'h7F, 7'h7F, 7'b0010010, 7'b1000000}, 4'b1111);
    applyLoad(16'h0000, 4'b0000);
    captureFrame();
    checkCapture("lz0000", {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1111);
    blankLz = 1'b0;

    waitFrame();
    load = 1'b1;
    data = 16'h0003;
    dp   = 4'b0000;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk); #1;
    checkOutput("load_on_frame_slot0", hex, 7'b0110000);
    checkOutput("load_on_frame_an", an, 4'hE);

    waitFrame();
    t0 = cycCount;
    waitFrame();
    t1 = cycCount;
    checkOutput("frame_period", t1 - t0, PERIOD);
    repeat (10) @(posedge clk); #1;
    en = 1'b0;
    repeat (10) @(posedge clk); #1;
    checkOutput("disabled_an", an, 4'hF);
    checkOutput("disabled_hex", hex, 7'h7F);
    en = 1'b1;
    waitFrame();
    t2 = cycCount;
    checkOutput("stretched_period", t2 - t1, PERIOD + 10);

    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("reset_an", an, 4'hF);
    checkOutput("reset_hex", hex, 7'h7F);
    checkOutput("reset_dp", dpOut, 1'b1);
    checkOutput("reset_frame", frame, 1'b0);
    blinkMask = 4'b0001;
    @(negedge clk);
    rst = 1'b0;
    for (int f = 0; f < 6; f++) begin
      repeat ((f == 0) ? 2 : PERIOD) @(posedge clk);
      #1;
      checkOutput($sformatf("blink_frame%0d_hex", f), hex,
                  (f == 2 || f == 3) ? 7'h7F : 7'b1000000);
      checkOutput($sformatf("blink_frame%0d_an", f), an, 4'hE);
    end

    for (int i = 0; i < 2000; i++) begin
      applyStimulus();
    end
    @(posedge clk); #1;
    load = 1'b0;
    en   = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checking = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
